// File: rtl/otp_array_responder_if.sv
// Controller <-> OTP array bundle: select/program drives in, status and sensed data out.
// dbg_state mirrors the responder FSM (0 IDLE, 1 PROGRAM, 2 VERIFY) for checkers.
interface otp_array_responder_if #(
    parameter int A = 2,
    parameter int B = 2
);
    logic [2*B-1:0] PL;
    logic [B-1:0]   BL;
    logic [A-1:0]   WLN;
    logic [A-1:0]   WLP;
    logic           PRG;
    logic           writing_successful;
    logic           output_read_circuit;
    logic           read_valid;
    logic           protocol_error;
    logic [A*B-1:0] fuse_state;
    logic [1:0]     dbg_state;

    // Selects are level inputs sampled every rising edge; there is no ready/valid
    // backpressure. read_valid qualifies output_read_circuit for exactly one cycle.
    modport master (
        output PL, BL, WLN, WLP, PRG,
        input  writing_successful, output_read_circuit, read_valid,
        input  protocol_error, fuse_state, dbg_state
    );
    modport slave (
        input  PL, BL, WLN, WLP, PRG,
        output writing_successful, output_read_circuit, read_valid,
        output protocol_error, fuse_state, dbg_state
    );
endinterface

// File: rtl/otp_array_responder.sv
// Behavioural stand-in for an A x B OTP fuse macro: programs fuses after PROG_CYCLES
// steady program pulses, verifies them, and answers reads after READ_LATENCY cycles.
module otp_array_responder #(
    parameter int             A            = 2,
    parameter int             B            = 2,
    parameter int             PROG_CYCLES  = 4,
    parameter int             READ_LATENCY = 2,
    parameter logic [A*B-1:0] WEAK_MASK    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    otp_array_responder_if.slave   bus
);
    localparam int CNTW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PROGRAM = 2'd1,
        S_VERIFY  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNTW-1:0]       r_count;
    logic [A*B-1:0]        r_cell;
    logic [A*B-1:0]        r_fuse;
    logic                  r_ws;
    logic                  r_perr;
    logic [READ_LATENCY-1:0] r_rd_v;
    logic [READ_LATENCY-1:0] r_rd_d;

    logic [B-1:0]   w_drive;
    logic [B-1:0]   w_guard;
    logic [A*B-1:0] w_pcell;
    logic [A*B-1:0] w_rcell;
    logic           w_illegal;
    logic           w_prog_sel;
    logic           w_read_sel;
    logic           w_push;

    // Cells are tracked as one-hot masks over the flat r*B+c index.
    always_comb begin
        w_drive = '0;
        w_guard = '0;
        w_pcell = '0;
        w_rcell = '0;
        for (int c = 0; c < B; c++) begin
            w_drive[c] = bus.PL[2*c];
            w_guard[c] = bus.PL[2*c+1];
        end
        for (int r = 0; r < A; r++) begin
            for (int c = 0; c < B; c++) begin
                w_pcell[r*B+c] = bus.WLP[r] & w_drive[c];
                w_rcell[r*B+c] = bus.WLN[r] & bus.BL[c];
            end
        end
    end

    assign w_illegal  = (bus.PRG && (|bus.WLN)) || (!bus.PRG && (|bus.WLP)) ||
                        !$onehot0(bus.WLP) || !$onehot0(bus.WLN) || !$onehot0(bus.BL) ||
                        (|(w_drive & w_guard));
    assign w_prog_sel = !w_illegal && bus.PRG && $onehot(bus.WLP) &&
                        $onehot(w_drive) && (w_guard == '0);
    assign w_read_sel = !w_illegal && !bus.PRG && (bus.WLP == '0) &&
                        $onehot(bus.WLN) && $onehot(bus.BL);
    assign w_push     = w_read_sel && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_cell  <= '0;
            r_fuse  <= '0;
            r_ws    <= 1'b1;
            r_perr  <= 1'b0;
        end else begin
            if (w_illegal)
                r_perr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_prog_sel) begin
                        r_cell <= w_pcell;
                        r_ws   <= 1'b0;
                        if (PROG_CYCLES == 1) begin
                            r_fuse  <= r_fuse | (w_pcell & ~WEAK_MASK);
                            r_count <= CNTW'(1);
                            r_state <= S_VERIFY;
                        end else begin
                            r_count <= CNTW'(1);
                            r_state <= S_PROGRAM;
                        end
                    end
                end
                S_PROGRAM: begin
                    if (!w_prog_sel) begin
                        r_state <= S_IDLE;
                    end else if (w_pcell != r_cell) begin
                        r_cell  <= w_pcell;
                        r_count <= CNTW'(1);
                    end else if (r_count == CNTW'(PROG_CYCLES - 1)) begin
                        r_fuse  <= r_fuse | (r_cell & ~WEAK_MASK);
                        r_count <= CNTW'(PROG_CYCLES);
                        r_state <= S_VERIFY;
                    end else begin
                        r_count <= r_count + CNTW'(1);
                    end
                end
                S_VERIFY: begin
                    r_ws    <= |(r_fuse & r_cell);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data is captured from the fuse array as it stands in the select cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_v <= '0;
            r_rd_d <= '0;
        end else begin
            r_rd_v[0] <= w_push;
            r_rd_d[0] <= w_push & (|(r_fuse & w_rcell));
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_v[i] <= r_rd_v[i-1];
                r_rd_d[i] <= r_rd_d[i-1];
            end
        end
    end

    assign bus.writing_successful  = r_ws;
    assign bus.output_read_circuit = r_rd_d[READ_LATENCY-1];
    assign bus.read_valid          = r_rd_v[READ_LATENCY-1];
    assign bus.protocol_error      = r_perr;
    assign bus.fuse_state          = r_fuse;
    assign bus.dbg_state           = r_state;
endmodule

// File: tb/tb_otp_array_responder.sv
// Scenario bench for otp_array_responder (2x2 array, cell (0,0) marked weak).
// Read results flow through an expected queue checked by a negedge monitor.
module tb_otp_array_responder;
    localparam int RL = 2;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [0:0] exp_q[$];
    int         due_q[$];
    logic [3:0] model_fuse;
    logic [0:0] mon_v;
    int         mon_d;

    otp_array_responder_if #(.A(2), .B(2)) bus ();

    otp_array_responder #(
        .A(2), .B(2), .PROG_CYCLES(4), .READ_LATENCY(RL), .WEAK_MASK(4'b0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.read_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: read_valid=1 at cycle %0d, want no result", cyc);
                end else begin
                    mon_v = exp_q.pop_front();
                    mon_d = due_q.pop_front();
                    if (bus.output_read_circuit !== mon_v[0] || mon_d != cyc) begin
                        n_err++;
                        $display("FAIL rd_data: got %b at cycle %0d, want %b at cycle %0d",
                                 bus.output_read_circuit, cyc, mon_v[0], mon_d);
                    end
                end
            end else begin
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    n_cmp++;
                    n_err++;
                    mon_v = exp_q.pop_front();
                    mon_d = due_q.pop_front();
                    $display("FAIL rd_missing: read_valid=%b at cycle %0d, want 1 with data %b",
                             bus.read_valid, cyc, mon_v[0]);
                end
                if (bus.output_read_circuit !== 1'b0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_idle_data: got %b with read_valid=0, want 0",
                             bus.output_read_circuit);
                end
            end
        end
    end

    // driver tasks
    task automatic set_idle();
        bus.PRG = 1'b0;
        bus.PL  = '0;
        bus.BL  = '0;
        bus.WLN = '0;
        bus.WLP = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic prog_cycle(input int r, input int c);
        set_idle();
        bus.PRG = 1'b1;
        bus.WLP = 2'(1 << r);
        bus.PL  = 4'(1 << (2 * c));
        step();
    endtask

    task automatic read_cycle(input int r, input int c, input bit accepted);
        set_idle();
        bus.WLN = 2'(1 << r);
        bus.BL  = 2'(1 << c);
        if (accepted) begin
            exp_q.push_back(model_fuse[r*2+c]);
            due_q.push_back(cyc + RL);
        end
        step();
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < 10 && due_q.size() > 0; i++) step();
        step();
        if (due_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d reads outstanding, want 0", due_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        due_q.delete();
        model_fuse = '0;
        step();
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.writing_successful !== 1'b1) begin n_err++;
            $display("FAIL reset_ws: got %b want 1", bus.writing_successful); end
        n_cmp++; if (bus.protocol_error !== 1'b0) begin n_err++;
            $display("FAIL reset_perr: got %b want 0", bus.protocol_error); end
        n_cmp++; if (bus.read_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_rv: got %b want 0", bus.read_valid); end
        n_cmp++; if (bus.fuse_state !== 4'b0000) begin n_err++;
            $display("FAIL reset_fuse: got %b want 0000", bus.fuse_state); end
        n_cmp++; if (bus.dbg_state !== 2'd0) begin n_err++;
            $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
        read_cycle(0, 1, 1);
        drain();
        n_cmp++; if (bus.writing_successful !== 1'b1) begin n_err++;
            $display("FAIL reset_ws_hold: got %b want 1", bus.writing_successful); end
    endtask

    task automatic test_program();
        prog_cycle(1, 0);
        n_cmp++; if (bus.writing_successful !== 1'b0 || bus.dbg_state !== 2'd1) begin n_err++;
            $display("FAIL prog_entry: ws=%b state=%0d, want ws=0 state=1",
                     bus.writing_successful, bus.dbg_state); end
        prog_cycle(1, 0);
        prog_cycle(1, 0);
        n_cmp++; if (bus.fuse_state !== 4'b0000) begin n_err++;
            $display("FAIL prog_early: fuse=%b want 0000", bus.fuse_state); end
        prog_cycle(1, 0);
        n_cmp++; if (bus.fuse_state !== 4'b0100 || bus.dbg_state !== 2'd2 ||
                     bus.writing_successful !== 1'b0) begin n_err++;
            $display("FAIL prog_blow: fuse=%b state=%0d ws=%b, want 0100 2 0",
                     bus.fuse_state, bus.dbg_state, bus.writing_successful); end
        idle_cycles(1);
        model_fuse[2] = 1'b1;
        n_cmp++; if (bus.writing_successful !== 1'b1 || bus.dbg_state !== 2'd0) begin n_err++;
            $display("FAIL prog_verify: ws=%b state=%0d, want 1 0",
                     bus.writing_successful, bus.dbg_state); end
        read_cycle(1, 0, 1);
        drain();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) prog_cycle(0, 1);
        idle_cycles(1);
        n_cmp++; if (bus.fuse_state !== 4'b0100 || bus.dbg_state !== 2'd0) begin n_err++;
            $display("FAIL abort_fuse: fuse=%b state=%0d, want 0100 0",
                     bus.fuse_state, bus.dbg_state); end
        idle_cycles(3);
        n_cmp++; if (bus.writing_successful !== 1'b0) begin n_err++;
            $display("FAIL abort_ws: got %b want 0", bus.writing_successful); end
    endtask

    task automatic test_weak();
        for (int i = 0; i < 4; i++) prog_cycle(0, 0);
        n_cmp++; if (bus.dbg_state !== 2'd2) begin n_err++;
            $display("FAIL weak_state: got %0d want 2", bus.dbg_state); end
        idle_cycles(2);
        n_cmp++; if (bus.writing_successful !== 1'b0 || bus.fuse_state !== 4'b0100) begin n_err++;
            $display("FAIL weak_result: ws=%b fuse=%b, want 0 0100",
                     bus.writing_successful, bus.fuse_state); end
        read_cycle(0, 0, 1);
        drain();
    endtask

    task automatic test_restart();
        prog_cycle(0, 1);
        prog_cycle(0, 1);
        for (int i = 0; i < 3; i++) prog_cycle(1, 1);
        n_cmp++; if (bus.fuse_state !== 4'b0100 || bus.dbg_state !== 2'd1) begin n_err++;
            $display("FAIL restart_count: fuse=%b state=%0d, want 0100 1",
                     bus.fuse_state, bus.dbg_state); end
        prog_cycle(1, 1);
        idle_cycles(1);
        model_fuse[3] = 1'b1;
        n_cmp++; if (bus.fuse_state !== 4'b1100 || bus.writing_successful !== 1'b1) begin n_err++;
            $display("FAIL restart_blow: fuse=%b ws=%b, want 1100 1",
                     bus.fuse_state, bus.writing_successful); end
    endtask

    task automatic test_reblow_read_ignored();
        prog_cycle(1, 0);
        n_cmp++; if (bus.writing_successful !== 1'b0) begin n_err++;
            $display("FAIL reblow_entry: ws=%b want 0", bus.writing_successful); end
        for (int i = 0; i < 3; i++) prog_cycle(1, 0);
        read_cycle(0, 0, 0);
        n_cmp++; if (bus.writing_successful !== 1'b1 || bus.fuse_state !== 4'b1100) begin n_err++;
            $display("FAIL reblow_verify: ws=%b fuse=%b, want 1 1100",
                     bus.writing_successful, bus.fuse_state); end
        idle_cycles(4);
    endtask

    task automatic test_back_to_back();
        read_cycle(0, 0, 1);
        read_cycle(1, 0, 1);
        read_cycle(0, 1, 1);
        read_cycle(1, 1, 1);
        for (int i = 0; i < 8; i++)
            read_cycle($urandom_range(0, 1), $urandom_range(0, 1), 1);
        drain();
    endtask

    task automatic test_protocol_error();
        set_idle();
        bus.PRG = 1'b1;
        bus.WLP = 2'b01;
        bus.WLN = 2'b01;
        bus.PL  = 4'b0001;
        step();
        n_cmp++; if (bus.protocol_error !== 1'b1 || bus.dbg_state !== 2'd0) begin n_err++;
            $display("FAIL perr_wln: perr=%b state=%0d, want 1 0",
                     bus.protocol_error, bus.dbg_state); end
        idle_cycles(3);
        n_cmp++; if (bus.protocol_error !== 1'b1 || bus.fuse_state !== 4'b1100) begin n_err++;
            $display("FAIL perr_sticky: perr=%b fuse=%b, want 1 1100",
                     bus.protocol_error, bus.fuse_state); end
        do_reset();
        n_cmp++; if (bus.protocol_error !== 1'b0) begin n_err++;
            $display("FAIL perr_clear: got %b want 0", bus.protocol_error); end
        set_idle();
        bus.PRG = 1'b1;
        bus.WLP = 2'b01;
        bus.PL  = 4'b1101;
        step();
        n_cmp++; if (bus.protocol_error !== 1'b1 || bus.dbg_state !== 2'd0) begin n_err++;
            $display("FAIL perr_pl11: perr=%b state=%0d, want 1 0",
                     bus.protocol_error, bus.dbg_state); end
        do_reset();
        set_idle();
        bus.WLP = 2'b01;
        bus.WLN = 2'b01;
        bus.BL  = 2'b01;
        step();
        n_cmp++; if (bus.protocol_error !== 1'b1) begin n_err++;
            $display("FAIL perr_wlp_read: got %b want 1", bus.protocol_error); end
        idle_cycles(4);
    endtask

    task automatic test_reset_mid_program();
        do_reset();
        for (int i = 0; i < 3; i++) prog_cycle(0, 1);
        reset = 1'b1;
        #2;
        n_cmp++; if (bus.writing_successful !== 1'b1 || bus.dbg_state !== 2'd0 ||
                     bus.fuse_state !== 4'b0000) begin n_err++;
            $display("FAIL midprog_reset: ws=%b state=%0d fuse=%b, want 1 0 0000",
                     bus.writing_successful, bus.dbg_state, bus.fuse_state); end
        prog_cycle(0, 1);
        reset = 1'b0;
        exp_q.delete();
        due_q.delete();
        model_fuse = '0;
        idle_cycles(1);
        read_cycle(0, 1, 1);
        drain();
    endtask

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        model_fuse = '0;
        reset = 1'b0;
        set_idle();
        test_reset();
        test_program();
        test_abort();
        test_weak();
        test_restart();
        test_reblow_read_ignored();
        test_back_to_back();
        test_protocol_error();
        test_reset_mid_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
